// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Results are computed from operands captured at the accepting edge and committed when Busy drops.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int DATA_W     = 32;
  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [63:0]       res_p1;
  logic              last_cycle;
  logic              commit;

  function automatic logic [63:0] mul_s(input logic signed [DATA_W-1:0] x,
                                        input logic signed [DATA_W-1:0] y);
    logic signed [63:0] px;
    logic signed [63:0] py;
    px = {{DATA_W{x[DATA_W-1]}}, x};
    py = {{DATA_W{y[DATA_W-1]}}, y};
    return px * py;
  endfunction

  function automatic logic [63:0] mul_u(input logic [DATA_W-1:0] x,
                                        input logic [DATA_W-1:0] y);
    logic [63:0] px;
    logic [63:0] py;
    px = {{DATA_W{1'b0}}, x};
    py = {{DATA_W{1'b0}}, y};
    return px * py;
  endfunction

  // Returns {remainder, quotient}; a zero divisor yields zero (the commit is suppressed anyway).
  function automatic logic [63:0] div_u(input logic [DATA_W-1:0] x,
                                        input logic [DATA_W-1:0] y);
    if (y == '0) return '0;
    return {x % y, x / y};
  endfunction

  // Magnitude divide then re-sign: truncation toward zero, remainder follows the dividend.
  // The most-negative / -1 case falls out naturally as 0x80000000 remainder 0.
  function automatic logic [63:0] div_s(input logic signed [DATA_W-1:0] x,
                                        input logic signed [DATA_W-1:0] y);
    logic [DATA_W-1:0] mx;
    logic [DATA_W-1:0] my;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    if (y == '0) return '0;
    mx = x[DATA_W-1] ? DATA_W'(-x) : DATA_W'(x);
    my = y[DATA_W-1] ? DATA_W'(-y) : DATA_W'(y);
    q  = mx / my;
    r  = mx % my;
    if (x[DATA_W-1] ^ y[DATA_W-1]) q = -q;
    if (x[DATA_W-1]) r = -r;
    return {r, q};
  endfunction

  // Stage p0: operand/op capture at the accepting edge
  always_ff @(posedge clk) begin
    if (state == S_IDLE && Start && !MDOp[2]) begin
      op_p0 <= MDOp[1:0];
      a_p0  <= A;
      b_p0  <= B;
    end
  end

  // Stage p1: result from captured operands, committed only on the final busy edge
  always_comb begin
    res_p1 = '0;
    case ({1'b0, op_p0})
      OP_MULT:  res_p1 = mul_s($signed(a_p0), $signed(b_p0));
      OP_MULTU: res_p1 = mul_u(a_p0, b_p0);
      OP_DIV:   res_p1 = div_s($signed(a_p0), $signed(b_p0));
      OP_DIVU:  res_p1 = div_u(a_p0, b_p0);
      default:  res_p1 = '0;
    endcase
  end

  assign last_cycle = (state == S_RUN) && (cnt == CNT_W'(1));
  assign commit     = last_cycle && !(op_p0[1] && (b_p0 == '0));
  assign Busy       = (state == S_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            case (MDOp)
              OP_MULT, OP_MULTU: begin
                state <= S_RUN;
                cnt   <= CNT_W'(MULT_CYCLES);
              end
              OP_DIV, OP_DIVU: begin
                state <= S_RUN;
                cnt   <= CNT_W'(DIV_CYCLES);
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (last_cycle) begin
            state <= S_IDLE;
            cnt   <= '0;
            if (commit) {HI, LO} <= res_p1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of back-to-back ops plus
// hand sequences for busy-time Start, last-cycle Start and mid-run reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[15];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge with Busy=0.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int ecyc);
    int n;
    bit stable;
    logic [31:0] hi0, lo0;
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(posedge clk);
    #1;
    Start = 1'b0; A = ~a; B = a ^ 32'h5a5a_a5a5;
    hi0 = HI; lo0 = LO;
    n = 0; stable = 1'b1;
    @(negedge clk);
    while (Busy && n < 50) begin
      n++;
      if (HI !== hi0 || LO !== lo0) stable = 1'b0;
      @(negedge clk);
    end
    check_int({name, "_busy"}, n, ecyc);
    if (ecyc > 0) check_int({name, "_stable"}, int'(stable), 1);
    check32({name, "_hi"}, HI, ehi);
    check32({name, "_lo"}, LO, elo);
  endtask

  initial begin
    int n;
    bit done;
    vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3]  = '{3'd3, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[5]  = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 10};
    vecs[6]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[7]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 5};
    vecs[8]  = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
    vecs[9]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[10] = '{3'd4, 32'h0000_0055, 32'h0000_0000, 32'h0000_0055, 32'h0000_0000, 0};
    vecs[11] = '{3'd5, 32'h0000_0066, 32'h0000_0000, 32'h0000_0055, 32'h0000_0066, 0};
    vecs[12] = '{3'd6, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0055, 32'h0000_0066, 0};
    vecs[13] = '{3'd7, 32'hCAFE_F00D, 32'h0000_0002, 32'h0000_0055, 32'h0000_0066, 0};
    vecs[14] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0055, 32'h0000_0066, 10};

    reset_n = 1'b1; Start = 1'b0; MDOp = 3'd0; A = '0; B = '0;
    #1 reset_n = 1'b0;
    #1;
    check_int("reset_busy", int'(Busy), 0);
    check32("reset_hi", HI, 32'h0);
    check32("reset_lo", LO, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].cyc);

    // MTLO attempted on busy cycle 2 of a MULT must be dropped
    Start = 1'b1; MDOp = 3'd0; A = 32'd2; B = 32'd3;
    @(posedge clk);
    #1 Start = 1'b0; A = '0; B = '0;
    n = 0;
    @(negedge clk);
    while (Busy && n < 50) begin
      n++;
      if (n == 2) begin Start = 1'b1; MDOp = 3'd5; A = 32'h1234; end
      else Start = 1'b0;
      @(negedge clk);
    end
    Start = 1'b0;
    check_int("busy_start_cycles", n, 5);
    check32("busy_start_lo", LO, 32'h6);
    check32("busy_start_hi", HI, 32'h0);

    // MTHI in the last busy cycle must be dropped
    Start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd7;
    @(posedge clk);
    #1 Start = 1'b0;
    n = 0;
    @(negedge clk);
    while (Busy && n < 50) begin
      n++;
      if (n == 10) begin Start = 1'b1; MDOp = 3'd4; A = 32'h99; end
      @(negedge clk);
    end
    Start = 1'b0;
    check_int("last_start_cycles", n, 10);
    check32("last_start_hi", HI, 32'h2);
    check32("last_start_lo", LO, 32'hE);
    @(negedge clk);
    check_int("last_start_idle", int'(Busy), 0);
    check32("last_start_hi_late", HI, 32'h2);

    // Reset on busy cycle 4 of a DIV aborts without commit
    Start = 1'b1; MDOp = 3'd2; A = 32'hFFFF_FFF9; B = 32'd2;
    @(posedge clk);
    #1 Start = 1'b0;
    n = 0; done = 1'b0;
    @(negedge clk);
    while (Busy && n < 50 && !done) begin
      n++;
      if (n == 4) begin
        reset_n = 1'b0;
        #1;
        check_int("midreset_busy", int'(Busy), 0);
        check32("midreset_hi", HI, 32'h0);
        check32("midreset_lo", LO, 32'h0);
        #1 reset_n = 1'b1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check_int("midreset_reached", int'(done), 1);
    @(negedge clk);
    run_op("post_reset_mthi", 3'd4, 32'hAB, 32'h0, 32'hAB, 32'h0, 0);
    run_op("post_reset_div", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
